// File: rtl/pgm_pkg.sv
// Shared types and constants for the packet-generator replay path.
// Holds RAM geometry, word tags and the scheduler state encoding.
package pgm_pkg;

  localparam int RAM_AW = 7;
  localparam int WORD_W = 134;
  localparam int RAM_DW = 144;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READ,
    S_GAP,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  function automatic logic is_tail(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 2] == TAG_TAIL;
  endfunction

endpackage

// File: rtl/pgm_gap_cnt.sv
// Loadable down-counter timing the idle gap between packet copies.
// o_tc flags the last gap cycle (count value 1).
module pgm_gap_cnt #(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [GAP_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - GAP_W'(1);
    end
  end

  assign o_tc = (r_cnt == GAP_W'(1));

endmodule

// File: rtl/pgm_sched.sv
// Replays the packet stored in PGM_RAM cfg_pkt_num times with cfg_gap idle
// cycles between copies; RAM read data is forwarded with a 2-cycle latency.
module pgm_sched #(
  parameter int RAM_AW = pgm_pkg::RAM_AW,
  parameter int CNT_W  = 32,
  parameter int GAP_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_start,
  input  logic [RAM_AW-1:0]          in_last_addr,
  input  logic [CNT_W-1:0]           cfg_pkt_num,
  input  logic [GAP_W-1:0]           cfg_gap,
  input  logic                       in_abort,
  output logic                       sched2ram_rd_en,
  output logic [RAM_AW-1:0]          sched2ram_addr,
  input  logic [pgm_pkg::RAM_DW-1:0] ram2sched_rdata,
  output logic [pgm_pkg::WORD_W-1:0] out_data,
  output logic                       out_data_wr,
  output logic                       out_valid,
  output logic                       out_valid_wr,
  input  logic                       in_alf,
  output logic                       out_busy,
  output logic                       out_finish,
  output logic                       out_err,
  output logic [CNT_W-1:0]           out_sent_cnt
);
  import pgm_pkg::*;

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [RAM_AW-1:0] r_addr;
  logic [RAM_AW-1:0] w_addr_nxt;
  logic [RAM_AW-1:0] r_last_addr;
  logic [CNT_W-1:0]  r_pkt_num;
  logic [GAP_W-1:0]  r_gap;
  logic [CNT_W-1:0]  r_sent_cnt;
  logic              r_abort;
  logic              r_busy;
  logic              r_finish;
  logic              r_err;

  logic              w_accept;
  logic              w_reject;
  logic              w_last_rd;
  logic              w_abort;
  logic              w_gap_load;
  logic              w_gap_dec;
  logic              w_gap_tc;

  logic              r_vld_p1;
  logic [WORD_W-1:0] r_data_p2;
  logic              r_vld_p2;
  logic              r_tail_p2;
  logic              w_unused_rdata;

  assign w_accept  = (r_state == S_IDLE) && in_start && (in_last_addr != '0);
  assign w_reject  = (r_state == S_IDLE) && in_start && (in_last_addr == '0);
  assign w_last_rd = (r_state == S_READ) && (r_addr == r_last_addr);
  assign w_abort   = r_abort || in_abort;

  pgm_gap_cnt #(
    .GAP_W (GAP_W)
  ) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_gap_load),
    .i_load_val (r_gap),
    .i_dec      (w_gap_dec),
    .o_tc       (w_gap_tc)
  );

  // Copy boundaries go straight to READ when downstream has room, so the
  // output shows exactly cfg_gap idle cycles; ARM only absorbs in_alf stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (cfg_pkt_num == '0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (w_abort) begin
          w_state_nxt = S_DRAIN;
        end else if (!in_alf) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_addr_nxt = r_addr + RAM_AW'(1);
        if (w_last_rd) begin
          w_addr_nxt = '0;
          if (((r_sent_cnt + CNT_W'(1)) == r_pkt_num) || w_abort) begin
            w_state_nxt = S_DRAIN;
          end else if (r_gap == '0) begin
            w_state_nxt = in_alf ? S_ARM : S_READ;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_load  = 1'b1;
          end
        end
      end
      S_GAP: begin
        w_gap_dec = 1'b1;
        if (w_abort) begin
          w_state_nxt = S_DRAIN;
        end else if (w_gap_tc) begin
          w_state_nxt = in_alf ? S_ARM : S_READ;
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_pkt_num   <= '0;
      r_gap       <= '0;
      r_sent_cnt  <= '0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_finish <= (r_state == S_DONE);
      r_err    <= w_reject;
      if (w_accept) begin
        r_last_addr <= in_last_addr;
        r_pkt_num   <= cfg_pkt_num;
        r_gap       <= cfg_gap;
        r_sent_cnt  <= '0;
        r_busy      <= 1'b1;
      end else if (w_last_rd) begin
        r_sent_cnt <= r_sent_cnt + CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      if (r_state == S_DONE) begin
        r_abort <= 1'b0;
      end else if ((r_state != S_IDLE) && in_abort) begin
        r_abort <= 1'b1;
      end
    end
  end

  // p1: RAM data valid; p2: registered output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p2 <= '0;
      r_vld_p2  <= 1'b0;
      r_tail_p2 <= 1'b0;
    end else begin
      r_vld_p1  <= sched2ram_rd_en;
      r_vld_p2  <= r_vld_p1;
      r_tail_p2 <= r_vld_p1 && is_tail(ram2sched_rdata[WORD_W-1:0]);
      if (r_vld_p1) begin
        r_data_p2 <= ram2sched_rdata[WORD_W-1:0];
      end
    end
  end

  assign w_unused_rdata  = ^ram2sched_rdata[RAM_DW-1:WORD_W];

  assign sched2ram_rd_en = (r_state == S_READ);
  assign sched2ram_addr  = r_addr;
  assign out_data        = r_data_p2;
  assign out_data_wr     = r_vld_p2;
  assign out_valid       = r_tail_p2;
  assign out_valid_wr    = r_tail_p2;
  assign out_busy        = r_busy;
  assign out_finish      = r_finish;
  assign out_err         = r_err;
  assign out_sent_cnt    = r_sent_cnt;

endmodule

// File: tb/tb_pgm_sched.sv
// Directed bench for pgm_sched: a table of replay runs plus hand-written
// sequences for start rejection, mid-copy reset, in_alf stalls and abort.
module tb_pgm_sched;
  import pgm_pkg::*;

  localparam int AW = 7;
  localparam int CW = 32;
  localparam int GW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_start = 1'b0;
  logic [AW-1:0]  in_last_addr = '0;
  logic [CW-1:0]  cfg_pkt_num = '0;
  logic [GW-1:0]  cfg_gap = '0;
  logic           in_abort = 1'b0;
  logic           in_alf = 1'b0;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [143:0]   rdata = '0;
  logic [133:0]   out_data;
  logic           out_data_wr, out_valid, out_valid_wr;
  logic           out_busy, out_finish, out_err;
  logic [CW-1:0]  out_sent_cnt;

  pgm_sched #(.RAM_AW(AW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_last_addr(in_last_addr),
    .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap), .in_abort(in_abort),
    .sched2ram_rd_en(rd_en), .sched2ram_addr(rd_addr), .ram2sched_rdata(rdata),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
    .out_valid_wr(out_valid_wr), .in_alf(in_alf), .out_busy(out_busy),
    .out_finish(out_finish), .out_err(out_err), .out_sent_cnt(out_sent_cnt)
  );

  always #5 clk = ~clk;

  logic [143:0] mem [0:127];
  always @(posedge clk) if (rd_en) rdata <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int run_L = 1;

  // Output monitor, sampled on the falling edge
  logic mon_clr = 1'b0;
  int m_words, m_tails, m_rds, m_fin, m_err, m_derr, m_bub;
  int m_max_idle, m_min_idle, m_prev_wr, m_last_tail, m_t_fin, m_t_err, m_n_rd0;
  int m_rd0 [0:3];
  logic m_busy_seen;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_words <= 0; m_tails <= 0; m_rds <= 0; m_fin <= 0; m_err <= 0;
      m_derr <= 0; m_bub <= 0; m_max_idle <= 0; m_min_idle <= 999;
      m_prev_wr <= -1; m_last_tail <= -1; m_t_fin <= -1; m_t_err <= -1;
      m_n_rd0 <= 0; m_busy_seen <= 1'b0;
    end else begin
      if (rd_en) begin
        m_rds <= m_rds + 1;
        if (rd_addr == '0 && m_n_rd0 < 4) begin
          m_rd0[m_n_rd0] <= cyc;
          m_n_rd0 <= m_n_rd0 + 1;
        end
      end
      if (out_data_wr) begin
        if (out_data !== mem[m_words % run_L][133:0]) m_derr <= m_derr + 1;
        if (m_prev_wr >= 0 && out_data[133:132] != TAG_HEAD && cyc != m_prev_wr + 1)
          m_bub <= m_bub + 1;
        if (m_prev_wr >= 0 && out_data[133:132] == TAG_HEAD) begin
          if (cyc - m_prev_wr - 1 > m_max_idle) m_max_idle <= cyc - m_prev_wr - 1;
          if (cyc - m_prev_wr - 1 < m_min_idle) m_min_idle <= cyc - m_prev_wr - 1;
        end
        m_prev_wr <= cyc;
        m_words <= m_words + 1;
      end
      if ((out_valid_wr !== (out_data_wr && out_data[133:132] == TAG_TAIL)) ||
          (out_valid !== out_valid_wr))
        m_derr <= m_derr + 1;
      if (out_valid_wr) begin
        m_tails <= m_tails + 1;
        m_last_tail <= cyc;
      end
      if (out_finish) begin
        m_fin <= m_fin + 1;
        m_t_fin <= cyc;
      end
      if (out_err) begin
        m_err <= m_err + 1;
        m_t_err <= cyc;
      end
      if (out_busy) m_busy_seen <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic fill(input int la);
    logic [159:0] rnd;
    logic [1:0]   tag;
    for (int a = 0; a < 128; a++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tag = (a == 0) ? TAG_HEAD : ((a == la) ? TAG_TAIL : TAG_BODY);
      mem[a] = {10'h2A5, tag, rnd[131:0]};
    end
    run_L = la + 1;
  endtask

  task automatic start_run(input int la, input int pn, input int gp, output int t0);
    @(posedge clk);
    #1;
    in_last_addr = AW'(la);
    cfg_pkt_num  = CW'(pn);
    cfg_gap      = GW'(gp);
    in_start     = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 in_start = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    int n;
    n = 0;
    while (m_fin == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (m_fin == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL finish_timeout: got none within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int outs_or();
    return int'({rd_en, |rd_addr, out_data_wr, |out_data, out_valid, out_valid_wr,
                 out_busy, out_finish, out_err, |out_sent_cnt});
  endfunction

  typedef struct {
    int la; int pn; int gp;
    int words; int tails; int idle; int fin_off;
  } vec_t;

  vec_t tbl [0:4];
  int t0, r;

  initial begin
    tbl[0] = '{3,   2, 4,   8, 2, 4, 16};
    tbl[1] = '{1,   3, 0,   6, 3, 0, 10};
    tbl[2] = '{5,   1, 7,   6, 1, 0, 10};
    tbl[3] = '{127, 2, 1, 256, 2, 1, 261};
    tbl[4] = '{2,   0, 3,   0, 0, 0, 2};

    // Reset state
    fill(3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_or(), 0);
    rst_n = 1'b1;
    mon_clear();

    // Start with last_addr==0 is rejected
    start_run(0, 5, 2, t0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_pulses", m_err, 1);
    chk("err_latency", m_t_err - t0, 1);
    chk("err_busy_seen", int'(m_busy_seen), 0);
    chk("err_reads", m_rds, 0);
    chk("err_finish", m_fin, 0);

    // Asynchronous reset in the middle of a copy
    fill(1);
    mon_clear();
    start_run(1, 5, 0, t0);
    repeat (4) @(posedge clk);
    #1;
    chk("prerst_active", int'({out_busy, rd_en, out_data_wr}), 7);
    chk("prerst_sent", int'(out_sent_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", outs_or(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_finish", m_fin, 0);
    chk("midrst_data", m_derr, 0);

    // in_alf stall in ARM, then raised mid-copy
    fill(3);
    mon_clear();
    in_alf = 1'b1;
    start_run(3, 2, 2, t0);
    repeat (10) @(posedge clk);
    #1 in_alf = 1'b0;
    r = cyc;
    repeat (2) @(posedge clk);
    #1 in_alf = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_alf = 1'b0;
    wait_fin(200);
    chk("alf_first_read", m_rd0[0] - r, 1);
    chk("alf_second_read", m_rd0[1] - r, 13);
    chk("alf_words", m_words, 8);
    chk("alf_bubbles", m_bub, 0);
    chk("alf_data", m_derr, 0);
    chk("alf_sent", int'(out_sent_cnt), 2);

    // Abort during the second copy; a start while busy is ignored
    mon_clear();
    start_run(3, 100, 2, t0);
    repeat (8) @(posedge clk);
    #1;
    in_abort = 1'b1;
    in_start = 1'b1;
    in_last_addr = '0;
    @(posedge clk);
    #1;
    in_abort = 1'b0;
    in_start = 1'b0;
    wait_fin(300);
    chk("abort_sent", int'(out_sent_cnt), 2);
    chk("abort_words", m_words, 8);
    chk("abort_tails", m_tails, 2);
    chk("abort_copies", m_n_rd0, 2);
    chk("abort_finish", m_fin, 1);
    chk("abort_fin_time", m_t_fin - t0, 14);
    chk("busy_start_ignored", m_err, 0);
    chk("abort_busy_end", int'(out_busy), 0);

    // Table of normal runs
    for (int i = 0; i < 5; i++) begin
      fill(tbl[i].la);
      mon_clear();
      start_run(tbl[i].la, tbl[i].pn, tbl[i].gp, t0);
      wait_fin(1000);
      chk($sformatf("v%0d_words", i), m_words, tbl[i].words);
      chk($sformatf("v%0d_reads", i), m_rds, tbl[i].words);
      chk($sformatf("v%0d_tails", i), m_tails, tbl[i].tails);
      chk($sformatf("v%0d_sent", i), int'(out_sent_cnt), tbl[i].pn);
      chk($sformatf("v%0d_finish", i), m_fin, 1);
      chk($sformatf("v%0d_fin_time", i), m_t_fin - t0, tbl[i].fin_off);
      chk($sformatf("v%0d_max_idle", i), m_max_idle, tbl[i].idle);
      chk($sformatf("v%0d_min_idle", i), m_min_idle, (tbl[i].pn > 1) ? tbl[i].idle : 999);
      chk($sformatf("v%0d_data", i), m_derr, 0);
      chk($sformatf("v%0d_bubbles", i), m_bub, 0);
      chk($sformatf("v%0d_busy", i), int'({m_busy_seen, out_busy}), 2);
      if (tbl[i].pn > 0)
        chk($sformatf("v%0d_tail_to_fin", i), m_t_fin - m_last_tail, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pgm_sched.md
# pgm_sched

Replay scheduler for the packet generator. After the write side has stored a test packet in PGM_RAM and pulsed its start flag, this block reads the packet back word by word and emits it on the datapath a configured number of times, with a configured idle gap between copies. It sits between PGM_RAM's read port and the downstream packet interface, and raises a finish pulse when the run ends or is aborted.

## Interface
- RAM_AW, 7, PGM_RAM address width (128 words max)
- CNT_W, 32, width of packet-count config and sent counter
- GAP_W, 16, width of inter-packet gap config
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_start  in  1  one-cycle pulse: stored packet ready, begin run
- in_last_addr  in  RAM_AW  RAM address of the stored packet's tail word; sampled on in_start
- cfg_pkt_num  in  CNT_W  copies to send; sampled on in_start
- cfg_gap  in  GAP_W  idle cycles between copies; sampled on in_start
- in_abort  in  1  stop the run after the current copy completes
- sched2ram_rd_en  out  1  RAM read strobe
- sched2ram_addr  out  RAM_AW  RAM read address
- ram2sched_rdata  in  144  RAM read data, valid 1 cycle after rd_en; bits [133:0] are the packet word
- out_data  out  134  packet word; [133:132] tag: 01 head, 11 body, 10 tail
- out_data_wr  out  1  out_data valid
- out_valid  out  1  packet good flag, always 1 when out_valid_wr
- out_valid_wr  out  1  pulses with each tail word
- in_alf  in  1  downstream almost-full
- out_busy  out  1  high from accepted start until finish pulse
- out_finish  out  1  one-cycle pulse at end of run
- out_err  out  1  one-cycle pulse: start rejected
- out_sent_cnt  out  CNT_W  copies emitted in current/last run

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- IDLE: in_start latches in_last_addr, cfg_pkt_num, cfg_gap; clears out_sent_cnt; sets out_busy. If in_last_addr==0, pulse out_err, stay IDLE, out_busy stays 0. If cfg_pkt_num==0, go to DONE. Otherwise go to ARM. in_abort is ignored in IDLE.
- ARM: wait while in_alf==1. When in_alf==0, go to READ with addr=0. in_alf is sampled only here, at copy boundaries.
- READ: rd_en=1 every cycle; addr increments from 0 to last_addr. On the cycle that reads last_addr, out_sent_cnt increments. Then:
  - If the new count equals cfg_pkt_num, or abort is latched, go to DRAIN.
  - Else if cfg_gap==0, go to ARM.
  - Else go to GAP.
- GAP: down-counter loaded with cfg_gap; go to ARM when it reaches 1. A latched abort sends GAP directly to DRAIN.
- DRAIN: wait 2 cycles for the pipeline to empty, then DONE.
- DONE: pulse out_finish, clear out_busy, return to IDLE.
- in_abort asserted while busy sets a sticky flag, cleared in DONE. Each copy always completes through its tail word.
- in_start while busy is ignored.
- Output path: RAM data is forwarded unmodified. out_data_wr is set on the cycle after rdata is valid. out_valid_wr=out_valid=1 when the forwarded word's tag is 10; otherwise both are 0.
- out_sent_cnt holds its value after DONE until the next accepted start.

## Timing
- Read issued at cycle t → out_data_wr at cycle t+2 (2-cycle latency).
- A copy of L=last_addr+1 words occupies L consecutive output cycles, with no bubbles inside a packet.
- Next copy's first read occurs no earlier than t_lastread+1+cfg_gap. The output therefore shows exactly cfg_gap idle cycles between copies when in_alf==0.
- out_finish occurs 1 cycle after the final tail word on out_data_wr (3 cycles after its read). For cfg_pkt_num==0, out_finish occurs 2 cycles after in_start.
- in_alf rising mid-copy does not stall the copy; the next copy waits in ARM.
- rst_n assertion mid-run: all outputs go to 0 immediately and state goes to IDLE. No finish pulse is generated.

## Structure
- Shared package pgm_pkg:
  - RAM_AW and the 134/144 data widths.
  - Tag constants TAG_HEAD=2'b01, TAG_BODY=2'b11, TAG_TAIL=2'b10.
  - Scheduler state enum {IDLE, ARM, READ, GAP, DRAIN, DONE}.
- One sub-module, pgm_gap_cnt: loadable GAP_W down-counter with a terminal-count output, used for GAP.

## Test plan
- last_addr=3, pkt_num=2, gap=4, in_alf=0 → two 4-word packets (01,11,11,10). There are exactly 4 idle cycles between them, out_valid_wr is asserted twice, out_sent_cnt=2, and out_finish occurs 1 cycle after the second tail.
- pkt_num=0 → no RAM reads, out_finish 2 cycles after start, out_sent_cnt=0. Start with last_addr=0 → out_err pulse, out_busy stays 0.
- gap=0, pkt_num=3, last_addr=1 → 6 back-to-back output words with no idle cycles.
- in_alf held 1 during ARM for 10 cycles, then released → the first read occurs 1 cycle after release. in_alf raised mid-copy → the copy completes unbroken.
- pkt_num=100, in_abort pulsed during the 2nd copy's body → the 2nd copy completes, no 3rd copy, out_sent_cnt=2, out_finish is pulsed.
- rst_n asserted mid-copy → all outputs 0 at once. After release, a new start runs normally from addr 0.
